// File: rtl/sp_ram_bist.sv
// March C- BIST initiator for a single-port SRAM bank port.
// Core requests pass straight through while idle; the BIST owns the port while busy.
module sp_ram_bist #(
  parameter int NUM_WORDS  = 8192,
  parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  core_en_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [31:0]           core_wdata_i,
  input  logic                  core_we_i,
  input  logic [3:0]            core_be_i,
  output logic [31:0]           core_rdata_o,
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [15:0]           fail_cnt_o
);

  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, CHK, DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OneAddr  = ADDR_WIDTH'(1);
  localparam logic [31:0]           Bg0      = 32'h0000_0000;
  localparam logic [31:0]           Bg1      = 32'hFFFF_FFFF;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;

  logic                  req_en_q, req_we_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [31:0]           req_wdata_q, req_exp_q;

  logic                  chk_vld_q;
  logic [31:0]           chk_exp_q;
  logic [ADDR_WIDTH-1:0] chk_addr_q;

  logic                  busy_q, done_q, fail_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [15:0]           fail_cnt_q;

  logic                  is_up, is_rw, last_op, term;
  logic                  nxt_en, nxt_we, nxt_busy;
  logic [31:0]           nxt_wdata, nxt_exp;
  logic                  start_ok, mismatch;

  always_comb begin
    is_up    = state_q inside {M0, M1, M2, M5};
    is_rw    = state_q inside {M1, M2, M3, M4};
    last_op  = !is_rw || wr_q;
    term     = is_up ? (addr_q == LastAddr) : (addr_q == '0);
    start_ok = (state_q == IDLE || state_q == DONE) && start_i;
    mismatch = chk_vld_q && (mem_rdata_i != chk_exp_q);
  end

  // Next operation to present: read then write per address in r,w elements.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = M0;
          addr_d  = '0;
          wr_d    = 1'b0;
        end
      end
      M0, M1, M2, M3, M4, M5: begin
        if (!last_op) begin
          wr_d = 1'b1;
        end else if (!term) begin
          addr_d = is_up ? addr_q + OneAddr : addr_q - OneAddr;
          wr_d   = 1'b0;
        end else begin
          wr_d = 1'b0;
          case (state_q)
            M0:      begin state_d = M1;  addr_d = '0;       end
            M1:      begin state_d = M2;  addr_d = '0;       end
            M2:      begin state_d = M3;  addr_d = LastAddr; end
            M3:      begin state_d = M4;  addr_d = LastAddr; end
            M4:      begin state_d = M5;  addr_d = '0;       end
            default: begin state_d = CHK; addr_d = '0;       end
          endcase
        end
      end
      CHK:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    nxt_en    = state_d inside {M0, M1, M2, M3, M4, M5};
    nxt_busy  = nxt_en || (state_d == CHK);
    nxt_we    = (state_d == M0) || ((state_d inside {M1, M2, M3, M4}) && wr_d);
    nxt_wdata = (state_d inside {M1, M3}) ? Bg1 : Bg0;
    nxt_exp   = (state_d inside {M2, M4}) ? Bg1 : Bg0;
  end

  // Read expectations ride one stage behind the request to meet the returning data.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      req_en_q    <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_exp_q   <= '0;
      chk_vld_q   <= 1'b0;
      chk_exp_q   <= '0;
      chk_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      busy_q      <= nxt_busy;
      done_q      <= (state_d == DONE);
      req_en_q    <= nxt_en;
      req_we_q    <= nxt_en && nxt_we;
      req_addr_q  <= nxt_en ? addr_d : '0;
      req_wdata_q <= (nxt_en && nxt_we) ? nxt_wdata : '0;
      req_exp_q   <= nxt_exp;
      chk_vld_q   <= req_en_q && !req_we_q;
      chk_exp_q   <= req_exp_q;
      chk_addr_q  <= req_addr_q;
      if (start_ok) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_cnt_q  <= '0;
      end else if (mismatch) begin
        fail_q <= 1'b1;
        if (fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
        if (!fail_q) fail_addr_q <= chk_addr_q;
      end
    end
  end

  assign mem_en_o     = busy_q ? req_en_q    : core_en_i;
  assign mem_addr_o   = busy_q ? req_addr_q  : core_addr_i;
  assign mem_wdata_o  = busy_q ? req_wdata_q : core_wdata_i;
  assign mem_we_o     = busy_q ? req_we_q    : core_we_i;
  assign mem_be_o     = busy_q ? 4'hF        : core_be_i;
  assign core_rdata_o = mem_rdata_i;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_cnt_o  = fail_cnt_q;

endmodule

// File: tb/tb_sp_ram_bist.sv
// Self-checking bench for sp_ram_bist: table-driven pass-through vectors plus
// March C- runs compared against an element-level reference model.
module tb_sp_ram_bist;

  localparam int NW = 16;
  localparam int AW = 4;

  logic          clk_i, rstn_i, start_i;
  logic          core_en_i, core_we_i;
  logic [AW-1:0] core_addr_i;
  logic [31:0]   core_wdata_i;
  logic [3:0]    core_be_i;
  logic [31:0]   core_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic [31:0]   memRdata;
  logic          busy_o, done_o, fail_o;
  logic [AW-1:0] fail_addr_o;
  logic [15:0]   fail_cnt_o;

  sp_ram_bist #(.NUM_WORDS(NW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
    .core_en_i(core_en_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_we_i(core_we_i), .core_be_i(core_be_i), .core_rdata_o(core_rdata_o),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_rdata_i(memRdata),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
    .fail_addr_o(fail_addr_o), .fail_cnt_o(fail_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural bank: one-cycle read latency, byte enables, per-word stuck-at masks on reads
  logic [31:0] ram     [NW];
  logic [31:0] sa0Mask [NW];
  logic [31:0] sa1Mask [NW];
  logic        ramClear;

  always @(posedge clk_i) begin
    if (ramClear) begin
      for (int i = 0; i < NW; i++) ram[i] <= '0;
    end else if (mem_en_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        memRdata <= (ram[mem_addr_o] & ~sa0Mask[mem_addr_o]) | sa1Mask[mem_addr_o];
      end
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } op_t;

  typedef struct {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          chkRd;
    logic [31:0]   expRd;
  } vec_t;

  op_t  expOps[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clearFaults();
    for (int i = 0; i < NW; i++) begin
      sa0Mask[i] = '0;
      sa1Mask[i] = '0;
    end
  endtask

  task automatic clearRam();
    core_en_i = 1'b0;
    ramClear  = 1'b1;
    tick();
    ramClear  = 1'b0;
  endtask

  // March C- ops: 0=r0 1=r1 2=w0 3=w1, -1 when the element has a single op
  function automatic int opOf(input int e, input int j);
    case (e)
      0:       return (j == 0) ? 2 : -1;
      1:       return (j == 0) ? 0 : 3;
      2:       return (j == 0) ? 1 : 2;
      3:       return (j == 0) ? 0 : 3;
      4:       return (j == 0) ? 1 : 2;
      default: return (j == 0) ? 0 : -1;
    endcase
  endfunction

  task automatic buildModel(output int expCnt, output int expAddr, output int firstIdx);
    logic [31:0] mm [NW];
    logic [31:0] val, expv;
    int a, op;
    op_t o;
    expOps.delete();
    expCnt = 0; expAddr = 0; firstIdx = -1;
    for (int i = 0; i < NW; i++) mm[i] = '0;
    for (int e = 0; e < 6; e++) begin
      for (int s = 0; s < NW; s++) begin
        a = (e == 3 || e == 4) ? NW - 1 - s : s;
        for (int j = 0; j < 2; j++) begin
          op = opOf(e, j);
          if (op < 0) continue;
          o.addr  = AW'(a);
          o.we    = (op >= 2);
          o.wdata = (op == 3) ? 32'hFFFF_FFFF : 32'h0;
          if (o.we) begin
            mm[a] = o.wdata;
          end else begin
            val  = (mm[a] & ~sa0Mask[a]) | sa1Mask[a];
            expv = (op == 1) ? 32'hFFFF_FFFF : 32'h0;
            if (val !== expv) begin
              if (firstIdx < 0) begin
                firstIdx = expOps.size();
                expAddr  = a;
              end
              expCnt++;
            end
          end
          expOps.push_back(o);
        end
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    core_en_i    = v.en;
    core_we_i    = v.we;
    core_addr_i  = v.addr;
    core_wdata_i = v.wdata;
    core_be_i    = v.be;
  endtask

  task automatic runBist(input string tag, input int rePulseAt, input int resetAt);
    int expCnt, expAddr, firstIdx, c, opErr, firstFail, expFirst;
    bit stopped;
    logic bad;
    op_t op;
    buildModel(expCnt, expAddr, firstIdx);
    opErr = 0; firstFail = -1; stopped = 0; c = 0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (busy_o === 1'b1 && c < 10*NW + 20 && !stopped) begin
      start_i      = (c == rePulseAt);
      core_en_i    = 1'($urandom_range(0, 1));
      core_we_i    = 1'($urandom_range(0, 1));
      core_addr_i  = AW'($urandom);
      core_wdata_i = $urandom;
      core_be_i    = 4'($urandom);
      #1;
      if (c == 0)
        checkOutput({tag, "_startClear"}, {done_o, fail_o, fail_addr_o, fail_cnt_o}, 64'd0);
      if (c < expOps.size()) begin
        op  = expOps[c];
        bad = (mem_en_o !== 1'b1) || (mem_be_o !== 4'hF) || (mem_addr_o !== op.addr) ||
              (mem_we_o !== op.we) || (op.we && (mem_wdata_o !== op.wdata));
      end else begin
        bad = (mem_en_o !== 1'b0);
      end
      if (bad) opErr++;
      if (fail_o === 1'b1 && firstFail < 0) firstFail = c;
      if (c == resetAt) begin
        core_en_i = 1'b0;
        start_i   = 1'b0;
        rstn_i    = 1'b0;
        #1;
        checkOutput({tag, "_rstBusy"},  busy_o,      0);
        checkOutput({tag, "_rstDone"},  done_o,      0);
        checkOutput({tag, "_rstFail"},  fail_o,      0);
        checkOutput({tag, "_rstMemEn"}, mem_en_o,    0);
        checkOutput({tag, "_rstCnt"},   fail_cnt_o,  0);
        checkOutput({tag, "_rstAddr"},  fail_addr_o, 0);
        checkOutput({tag, "_rstOps"},   opErr,       0);
        stopped = 1;
      end else begin
        tick();
        c++;
      end
    end
    start_i   = 1'b0;
    core_en_i = 1'b0;
    if (!stopped) begin
      if (fail_o === 1'b1 && firstFail < 0) firstFail = c;
      expFirst = (firstIdx < 0) ? -1 : firstIdx + 2;
      checkOutput({tag, "_busyLen"},  c,           10*NW + 1);
      checkOutput({tag, "_opSeq"},    opErr,       0);
      checkOutput({tag, "_done"},     done_o,      1);
      checkOutput({tag, "_fail"},     fail_o,      (expCnt > 0) ? 1 : 0);
      checkOutput({tag, "_failCnt"},  fail_cnt_o,  expCnt);
      checkOutput({tag, "_failAddr"}, fail_addr_o, (expCnt > 0) ? expAddr : 0);
      checkOutput({tag, "_failTime"}, firstFail,   expFirst);
    end
  endtask

  initial begin : stimulus
    logic [31:0] shadow [NW];
    logic [31:0] merged;
    int nonZero, mirrorErr, w, b;
    vec_t v;

    vecs[0] = '{1'b1, 1'b1, 4'd7, 32'hDEAD_BEEF, 4'b0011, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 4'd7, 32'h0,         4'hF,    1'b1, 32'h0000_BEEF};
    vecs[2] = '{1'b1, 1'b1, 4'd7, 32'h1234_5678, 4'b1100, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 4'd7, 32'h0,         4'hF,    1'b1, 32'h1234_BEEF};
    vecs[4] = '{1'b0, 1'b1, 4'd2, 32'hCAFE_F00D, 4'hF,    1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 4'd2, 32'h0,         4'hF,    1'b1, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 4'd0, 32'hA5A5_5A5A, 4'b0101, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 4'd0, 32'h0,         4'hF,    1'b1, 32'h00A5_005A};

    rstn_i = 1'b0; start_i = 1'b0; ramClear = 1'b0;
    core_en_i = 1'b0; core_we_i = 1'b0; core_addr_i = '0; core_wdata_i = '0; core_be_i = '0;
    clearFaults();
    #3;
    checkOutput("reset_busy",     busy_o,      0);
    checkOutput("reset_done",     done_o,      0);
    checkOutput("reset_fail",     fail_o,      0);
    checkOutput("reset_failAddr", fail_addr_o, 0);
    checkOutput("reset_failCnt",  fail_cnt_o,  0);
    checkOutput("reset_memEn",    mem_en_o,    0);
    tick();
    rstn_i = 1'b1;
    tick();

    $display("[TB] idle pass-through vectors");
    clearRam();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("pt%0d_ctrl", i), {mem_en_o, mem_we_o, mem_addr_o, mem_be_o},
                  {vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].be});
      checkOutput($sformatf("pt%0d_wdata", i), mem_wdata_o, vecs[i].wdata);
      tick();
      if (vecs[i].chkRd) checkOutput($sformatf("pt%0d_rdata", i), core_rdata_o, vecs[i].expRd);
    end

    $display("[TB] random pass-through traffic");
    clearRam();
    for (int i = 0; i < NW; i++) shadow[i] = '0;
    mirrorErr = 0;
    for (int i = 0; i < 40; i++) begin
      v.en = 1'b1; v.we = 1'($urandom_range(0, 1)); v.addr = AW'($urandom);
      v.wdata = $urandom; v.be = 4'($urandom); v.chkRd = 1'b0; v.expRd = '0;
      applyStimulus(v);
      #1;
      if ({mem_en_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !== {v.en, v.we, v.addr, v.be, v.wdata})
        mirrorErr++;
      tick();
      if (v.we) begin
        merged = shadow[v.addr];
        for (int k = 0; k < 4; k++) if (v.be[k]) merged[8*k +: 8] = v.wdata[8*k +: 8];
        shadow[v.addr] = merged;
      end else begin
        checkOutput($sformatf("rnd%0d_rdata", i), core_rdata_o, shadow[v.addr]);
      end
    end
    checkOutput("rnd_mirror", mirrorErr, 0);
    core_en_i = 1'b0;

    $display("[TB] fault-free run with ignored re-start");
    runBist("clean", 20, -1);
    nonZero = 0;
    for (int i = 0; i < NW; i++) if (ram[i] !== 32'h0) nonZero++;
    checkOutput("clean_ramZero", nonZero, 0);
    repeat (3) tick();
    checkOutput("clean_doneHold", {busy_o, done_o}, 2'b01);

    $display("[TB] stuck-at-0 bit 5 of word 3");
    sa0Mask[3] = 32'h0000_0020;
    runBist("sa0", -1, -1);
    checkOutput("sa0_cntFixed",  fail_cnt_o,  2);
    checkOutput("sa0_addrFixed", fail_addr_o, 3);

    $display("[TB] stuck-at-1 bit 0 of words 2 and 9");
    clearFaults();
    sa1Mask[2] = 32'h1;
    sa1Mask[9] = 32'h1;
    runBist("sa1", -1, -1);
    checkOutput("sa1_cntFixed",  fail_cnt_o,  6);
    checkOutput("sa1_addrFixed", fail_addr_o, 2);

    for (int r = 0; r < 2; r++) begin
      $display("[TB] random fault run %0d", r);
      clearFaults();
      for (int k = 0; k < 2; k++) begin
        w = $urandom_range(0, NW - 1);
        b = $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) sa0Mask[w] = sa0Mask[w] | (32'h1 << b);
        else                           sa1Mask[w] = sa1Mask[w] | (32'h1 << b);
      end
      runBist($sformatf("rnd%0d", r), -1, -1);
    end

    $display("[TB] reset abort at busy cycle 50");
    clearFaults();
    runBist("abort", -1, 50);
    #2;
    rstn_i = 1'b1;
    tick();
    v = '{1'b1, 1'b1, 4'd5, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0};
    applyStimulus(v);
    #1;
    checkOutput("abort_ptCtrl", {busy_o, mem_en_o, mem_we_o, mem_addr_o, mem_be_o},
                {1'b0, 1'b1, 1'b1, 4'd5, 4'hF});
    checkOutput("abort_ptWdata", mem_wdata_o, 32'hA5A5_A5A5);
    tick();
    v.we = 1'b0;
    applyStimulus(v);
    tick();
    checkOutput("abort_ptRdata", core_rdata_o, 32'hA5A5_A5A5);
    core_en_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sp_ram_bist.md
Name: sp_ram_bist

Overview:
- March C- built-in self-test initiator for the single-port SRAM bank port (en/addr/wdata/we/be request, registered rdata one cycle later).
- Sits between the core data port and the bank.
- When idle, the core request passes straight through.
- When running, the BIST owns the port, walks every word, compares read data and reports status.

Parameters:
- NUM_WORDS, 8192, words in the attached bank array (power of two, >=2).
- ADDR_WIDTH, $clog2(NUM_WORDS), word address width.

Ports:
- clk_i  input  1  clock
- rstn_i  input  1  asynchronous reset, active-low
- start_i  input  1  start pulse; accepted only when busy_o=0
- core_en_i  input  1  core request enable
- core_addr_i  input  ADDR_WIDTH  core word address
- core_wdata_i  input  32  core write data
- core_we_i  input  1  core write enable
- core_be_i  input  4  core byte enables
- core_rdata_o  output  32  read data to core
- mem_en_o  output  1  bank enable
- mem_addr_o  output  ADDR_WIDTH  bank address
- mem_wdata_o  output  32  bank write data
- mem_we_o  output  1  bank write enable
- mem_be_o  output  4  bank byte enables
- mem_rdata_i  input  32  bank read data, valid the cycle after a read request
- busy_o  output  1  BIST owns the port
- done_o  output  1  run complete, held until next start
- fail_o  output  1  sticky mismatch flag for the current/last run
- fail_addr_o  output  ADDR_WIDTH  address of the first mismatch
- fail_cnt_o  output  16  mismatch count, saturates at 16'hFFFF

Behaviour:
- Reset values: busy_o/done_o/fail_o = 0; fail_addr_o/fail_cnt_o = 0; all internal BIST request registers = 0.
- Port mux (combinational):
  - busy_o=0: mem_* = core_*.
  - busy_o=1: mem_* = registered BIST request. core_en_i is ignored and no core access is made; the core is stalled externally.
  - core_rdata_o = mem_rdata_i always.
- BIST requests: mem_be_o = 4'hF. Backgrounds: "0" = 32'h0000_0000, "1" = 32'hFFFF_FFFF.
- Elements, one operation per cycle, no idle cycles between operations or elements:
  - M0 up(w0)
  - M1 up(r0,w1)
  - M2 up(r1,w0)
  - M3 down(r0,w1)
  - M4 down(r1,w0)
  - M5 up(r0)
- Address order: "up" is 0..NUM_WORDS-1; "down" is NUM_WORDS-1..0.
- In r,w elements, each address gets a read cycle then a write cycle at the same address.
- FSM states: IDLE, M0, M1, M2, M3, M4, M5, CHK, DONE.
  - Each Mx with a read/write sub-phase bit; one address counter.
  - Element change on terminal address and last op of that address. Address reloads to 0 for up elements, NUM_WORDS-1 for down.
  - M5 terminal read goes to CHK for one cycle (final compare), then DONE.
  - DONE sets done_o=1 and busy_o=0. It behaves as IDLE for start_i.
- Start: start_i=1 in IDLE/DONE at edge T:
  - busy_o=1, done_o=0, fail_o=0, fail_cnt_o=0, fail_addr_o=0 from T+1.
  - First M0 write is presented in cycle T+1.
- start_i while busy_o=1 is ignored.
- Busy duration is exactly 10*NUM_WORDS+1 cycles. done_o rises the cycle after CHK.
- Compare:
  - The expected value and address of each read are registered with the request.
  - In the following cycle, mem_rdata_i is compared against the expected value.
  - On mismatch: fail_o<=1; fail_cnt_o increments, saturating; fail_addr_o captured only if fail_o was 0 (first failure).
  - A compare pending from the last read of an element completes normally while the next element issues.
- Asynchronous reset mid-run: immediate abort. All outputs return to reset values and the port reverts to core pass-through. No resume.
- Bank memory contents after a fault-free run: all words 32'h0.

Test Plan:
- Use a behavioural 1-cycle-latency RAM model for all scenarios.
- Fault-free, NUM_WORDS=16: pulse start_i -> busy_o high exactly 161 cycles; done_o=1; fail_o=0; fail_cnt_o=0; RAM all zero.
- Stuck-at-0 on bit 5 of word 3 -> fail_o=1, fail_addr_o=3, fail_cnt_o=2 (M2 r1 and M4 r1); first mismatch flagged the cycle after the M2 read of address 3.
- Stuck-at-1 on bit 0 of words 2 and 9 -> fail_addr_o=2, fail_cnt_o=6 (M1, M3, M5 reads at each word).
- Idle pass-through: core write 32'hDEADBEEF to address 7 with be=4'b0011, then read -> mem_* mirror core_* each cycle; core_rdata_o=32'h0000BEEF the next cycle (RAM pre-zeroed).
- start_i re-pulsed at busy cycle 20 -> no effect, run length still 161. start_i after done -> done_o drops, fail status cleared, new run completes.
- rstn_i asserted at busy cycle 50 -> busy_o/done_o/fail_o/mem_en_o (core_en_i=0) go 0 immediately; following core access passes through.
